id_hazard_ctrl: RTL

ID_HAZARD_CTRL -- requirements
Module: id_hazard_ctrl

---
 rtl/id_hazard_ctrl_pkg.sv | 19 +
 rtl/id_hazard_ctrl_det.sv | 50 +++++
 rtl/id_hazard_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/id_hazard_ctrl_pkg.sv
// id_hazard_ctrl_pkg
//   Shared definitions for the decode-stage hazard controller:
//   - state_t : RUN / BUBBLE / FLUSH controller states
//   - OPC_*   : RV32 major opcodes whose source registers are tracked
package id_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_BUBBLE = 2'd1,
        ST_FLUSH  = 2'd2
    } state_t;

    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

endpackage

// File: rtl/id_hazard_ctrl_det.sv
// id_hazard_det
//   Combinational load-use hazard detector. Decodes which source registers
//   the held instruction actually reads and compares them against the
//   destination of a LOAD sitting in EX.
// Ports:
//   instr       in  25  low bits of the held instruction (opcode, rs1, rs2)
//   held_valid  in  1   held register contains an instruction
//   ex_mem_read in  1   EX instruction is a LOAD
//   ex_rd       in  5   EX destination register
//   hazard      out 1   load-use hazard present
module id_hazard_det
    import id_hazard_ctrl_pkg::*;
(
    input  logic [24:0] instr,
    input  logic        held_valid,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd,
    output logic        hazard
);

    logic [6:0] opcode;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use_rs1;
    logic       use_rs2;

    assign opcode = instr[6:0];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];

    // Only formats that really read a register may raise a hazard; for
    // I-type the rs2 field is immediate bits and must be ignored.
    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (opcode)
            OPC_OPIMM, OPC_LOAD: use_rs1 = 1'b1;
            OPC_STORE, OPC_BRANCH, OPC_OP: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            default: ;
        endcase
    end

    // x0 is never written, so a LOAD to x0 cannot create a dependency.
    assign hazard = held_valid && ex_mem_read && (ex_rd != 5'd0) &&
                    ((use_rs1 && (rs1 == ex_rd)) || (use_rs2 && (rs2 == ex_rd)));

endmodule

// File: rtl/id_hazard_ctrl.sv
// id_hazard_ctrl
//   IF/ID holding register with load-use bubble insertion and branch flush.
//   Optional performance counters are built when ID_HAZARD_CNT_EN is defined.
// Ports:
//   i_clk, i_rst_n              clock, async active-low reset
//   i_if_valid / o_if_ready     fetch-to-decode handshake
//   i_if_instr / i_if_pc        fetched instruction and PC
//   o_id_valid / i_ex_ready     decode-to-execute handshake
//   o_id_instr / o_id_pc        held instruction and PC
//   i_ex_memRead / i_ex_rd      EX holds a LOAD, and its destination
//   i_branch_taken              EX redirect, younger instructions are dead
//   o_stall / o_flush           bubble / flush active this cycle
//   o_stall_cnt / o_flush_cnt   saturating counters (ID_HAZARD_CNT_EN only)
module id_hazard_ctrl
    import id_hazard_ctrl_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_if_valid,
    output logic            o_if_ready,
    input  logic [XLEN-1:0] i_if_instr,
    input  logic [XLEN-1:0] i_if_pc,
    output logic            o_id_valid,
    input  logic            i_ex_ready,
    output logic [XLEN-1:0] o_id_instr,
    output logic [XLEN-1:0] o_id_pc,
    input  logic            i_ex_memRead,
    input  logic [4:0]      i_ex_rd,
    input  logic            i_branch_taken,
    output logic            o_stall,
    output logic            o_flush
`ifdef ID_HAZARD_CNT_EN
    ,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
`endif
);

    state_t state;
    logic   held_valid;
    logic   hazard;
    logic   accept;
    logic   transfer;

    id_hazard_det u_det (
        .instr      (o_id_instr[24:0]),
        .held_valid (held_valid),
        .ex_mem_read(i_ex_memRead),
        .ex_rd      (i_ex_rd),
        .hazard     (hazard)
    );

    always_comb begin
        o_if_ready = 1'b0;
        o_id_valid = 1'b0;
        case (state)
            ST_RUN: begin
                o_id_valid = held_valid && !hazard;
                o_if_ready = !held_valid || (i_ex_ready && !hazard);
            end
            // Keep fetch draining wrong-path instructions; they are dropped.
            ST_FLUSH: o_if_ready = 1'b1;
            default: ;
        endcase
    end

    assign o_stall  = (state == ST_BUBBLE);
    assign o_flush  = (state == ST_FLUSH);
    assign accept   = i_if_valid && o_if_ready;
    assign transfer = o_id_valid && i_ex_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_RUN;
        end else if (i_branch_taken) begin
            state <= ST_FLUSH;
        end else begin
            case (state)
                ST_RUN:  if (hazard) state <= ST_BUBBLE;
                default: state <= ST_RUN;
            endcase
        end
    end

    // Branch beats everything; BUBBLE freezes the register; FLUSH discards.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            held_valid <= 1'b0;
            o_id_instr <= '0;
            o_id_pc    <= '0;
        end else if (i_branch_taken || state == ST_FLUSH) begin
            held_valid <= 1'b0;
        end else if (state == ST_RUN) begin
            if (accept) begin
                held_valid <= 1'b1;
                o_id_instr <= i_if_instr;
                o_id_pc    <= i_if_pc;
            end else if (transfer) begin
                held_valid <= 1'b0;
            end
        end
    end

`ifdef ID_HAZARD_CNT_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_stall_cnt <= '0;
            o_flush_cnt <= '0;
        end else begin
            if (o_stall && (o_stall_cnt != '1)) o_stall_cnt <= o_stall_cnt + CNT_W'(1);
            if (o_flush && (o_flush_cnt != '1)) o_flush_cnt <= o_flush_cnt + CNT_W'(1);
        end
    end
`endif

endmodule
